// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a small response FIFO toward decode.
// Ports:
//   clk, rst_n                            clock, asynchronous active-low reset
//   mem_req_valid/addr/ready              word fetch request channel
//   mem_resp_valid/data/err               in-order fetch responses
//   redirect_valid/pc                     PC load from jump/branch logic (highest priority)
//   inst_valid/inst/inst_pc/inst_fault    FIFO head toward decode, consumed with inst_ready
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [1:0]  inst_fault,
  input  logic        inst_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic {RUN, STOP} state_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  fault;
  } entry_t;
  state_t                 state_q, state_d;
  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic [31:0]            resp_pc_q, resp_pc_d;
  logic [CW-1:0]          out_q, out_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          rd_q, rd_d;
  logic [AW-1:0]          wr_q, wr_d;
  logic [15:0]            stale_q, stale_d;
  entry_t [DEPTH-1:0]     ent_q, ent_d;
  logic [CW:0]            busy;
  logic                   req_ok, req_fire, resp_live, deq, mis;
  entry_t                 head;
  assign busy      = {1'b0, out_q} + {1'b0, cnt_q};
  assign req_ok    = (state_q == RUN) && (busy < (CW+1)'(DEPTH)) && !redirect_valid;
  assign req_fire  = req_ok && mem_req_ready;
  // A response landing in a redirect cycle belongs to the old stream and is dropped.
  assign resp_live = mem_resp_valid && (stale_q == '0) && !redirect_valid;
  assign deq       = inst_valid && inst_ready;
  assign mis       = |redirect_pc[1:0];
  assign head      = ent_q[rd_q];
  assign mem_req_valid = rst_n && req_ok;
  assign mem_req_addr  = fetch_pc_q;
  assign inst_valid    = cnt_q != '0;
  assign inst          = inst_valid ? head.inst : '0;
  assign inst_pc       = inst_valid ? head.pc : '0;
  assign inst_fault    = inst_valid ? head.fault : '0;
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    stale_d    = stale_q;
    ent_d      = ent_q;
    if (redirect_valid) begin
      // Every in-flight fetch becomes stale, except a response arriving right now,
      // which retires either one stale slot or one outstanding fetch.
      stale_d    = stale_q + 16'(out_q) - 16'(mem_resp_valid);
      out_d      = '0;
      rd_d       = '0;
      wr_d       = AW'(mis);
      cnt_d      = CW'(mis);
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = redirect_pc;
      state_d    = mis ? STOP : RUN;
      ent_d[0]   = '{inst: NOP, pc: redirect_pc, fault: 2'd1};
    end else begin
      fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
      stale_d    = (mem_resp_valid && stale_q != '0) ? stale_q - 16'd1 : stale_q;
      out_d      = out_q + CW'(req_fire) - CW'(resp_live);
      cnt_d      = cnt_q + CW'(resp_live) - CW'(deq);
      rd_d       = deq ? rd_q + AW'(1) : rd_q;
      if (resp_live) begin
        ent_d[wr_q] = '{inst: mem_resp_err ? NOP : mem_resp_data, pc: resp_pc_q,
                        fault: mem_resp_err ? 2'd2 : 2'd0};
        wr_d        = wr_q + AW'(1);
        resp_pc_d   = resp_pc_q + 32'd4;
        state_d     = mem_resp_err ? STOP : state_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      stale_q    <= '0;
      ent_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      stale_q    <= stale_d;
      ent_q      <= ent_d;
    end
  end
endmodule
